// File: rtl/pos_selector_if.sv
// rtl/pos_selector_if.sv - button inputs and cursor outputs of pos_selector
interface pos_selector_if #(
   parameter int N_POS = 4
);
   localparam int PW = $clog2(N_POS + 1);

   logic             left;
   logic             right;
   logic [N_POS-1:0] sel;
   logic [PW-1:0]    pos;
   logic             at_min;
   logic             at_max;
   logic             moved;

   modport master (
      output left,
      output right,
      input  sel,
      input  pos,
      input  at_min,
      input  at_max,
      input  moved
   );

   modport slave (
      input  left,
      input  right,
      output sel,
      output pos,
      output at_min,
      output at_max,
      output moved
   );
endinterface

// File: rtl/pos_selector.sv
// rtl/pos_selector.sv - button-driven cursor register, one-hot and binary outputs
// Optional hold-to-repeat stepping is built when POS_AUTOREPEAT_EN is defined.
module pos_selector #(
   parameter int N_POS      = 4,
   parameter bit WRAP       = 1'b0,
   parameter int RPT_DELAY  = 16,
   parameter int RPT_PERIOD = 4
) (
   input logic          clk,
   input logic          first_pos,
   pos_selector_if.slave bus
);
   localparam int               PW      = $clog2(N_POS + 1);
   localparam logic [PW-1:0]    POS_MIN = PW'(1);
   localparam logic [PW-1:0]    POS_MAX = PW'(N_POS);
   localparam logic [N_POS-1:0] SEL_MIN = N_POS'(1);

   // bit 0 = s1, bit 1 = s2, bit 2 = s3 (edge-detect delay)
   logic [2:0]       l_sync;
   logic [2:0]       r_sync;
   logic             l_edge;
   logic             r_edge;
   logic             lp;
   logic             rp;
   logic [PW-1:0]    pos_q;
   logic [PW-1:0]    pos_d;
   logic [N_POS-1:0] sel_q;
   logic             at_min_q;
   logic             at_max_q;
   logic             moved_q;
   logic             move;

   always_ff @(posedge clk or posedge first_pos) begin
      if (first_pos) begin
         l_sync <= '0;
         r_sync <= '0;
      end else begin
         l_sync <= {l_sync[1:0], bus.left};
         r_sync <= {r_sync[1:0], bus.right};
      end
   end

   assign l_edge = l_sync[1] & ~l_sync[2];
   assign r_edge = r_sync[1] & ~r_sync[2];

`ifdef POS_AUTOREPEAT_EN
   localparam int CW = $clog2(RPT_DELAY + 1);

   logic [CW-1:0] rpt_cnt;
   logic          hold_one;
   logic          rpt;

   assign hold_one = l_sync[1] ^ r_sync[1];
   assign rpt      = hold_one && !(l_edge || r_edge) && (rpt_cnt == CW'(RPT_DELAY));

   // Counter holds cycles since the press; after the first repeat it is pulled
   // back so the next repeat lands RPT_PERIOD cycles later.
   always_ff @(posedge clk or posedge first_pos) begin
      if (first_pos) begin
         rpt_cnt <= '0;
      end else if (!hold_one) begin
         rpt_cnt <= '0;
      end else if (l_edge || r_edge) begin
         rpt_cnt <= CW'(1);
      end else if (rpt) begin
         rpt_cnt <= CW'(RPT_DELAY - RPT_PERIOD + 1);
      end else begin
         rpt_cnt <= rpt_cnt + CW'(1);
      end
   end

   assign lp = l_edge | (rpt & l_sync[1]);
   assign rp = r_edge | (rpt & r_sync[1]);
`else
   assign lp = l_edge;
   assign rp = r_edge;
`endif

   // Bounds are tested before the add/subtract so pos never leaves 1..N_POS.
   always_comb begin
      pos_d = pos_q;
      move  = 1'b0;
      if (lp && !rp) begin
         if (pos_q != POS_MIN) begin
            pos_d = pos_q - POS_MIN;
            move  = 1'b1;
         end else if (WRAP) begin
            pos_d = POS_MAX;
            move  = 1'b1;
         end
      end else if (rp && !lp) begin
         if (pos_q != POS_MAX) begin
            pos_d = pos_q + POS_MIN;
            move  = 1'b1;
         end else if (WRAP) begin
            pos_d = POS_MIN;
            move  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge first_pos) begin
      if (first_pos) begin
         pos_q    <= POS_MIN;
         sel_q    <= SEL_MIN;
         at_min_q <= 1'b1;
         at_max_q <= 1'b0;
         moved_q  <= 1'b0;
      end else begin
         moved_q <= move;
         if (move) begin
            pos_q    <= pos_d;
            sel_q    <= SEL_MIN << (pos_d - POS_MIN);
            at_min_q <= (pos_d == POS_MIN);
            at_max_q <= (pos_d == POS_MAX);
         end
      end
   end

   assign bus.pos    = pos_q;
   assign bus.sel    = sel_q;
   assign bus.at_min = at_min_q;
   assign bus.at_max = at_max_q;
   assign bus.moved  = moved_q;
endmodule

// File: tb/tb_pos_selector.sv
// tb/tb_pos_selector.sv - randomized bench for pos_selector against a behavioural model
module tb_pos_selector;
   localparam int ND = 3;

   logic clk = 1'b0;
   logic first_pos;
   logic left;
   logic right;

   always #5 clk = ~clk;

   pos_selector_if #(.N_POS(4))  if_a ();
   pos_selector_if #(.N_POS(6))  if_b ();
   pos_selector_if #(.N_POS(16)) if_c ();

   assign if_a.left  = left;
   assign if_a.right = right;
   assign if_b.left  = left;
   assign if_b.right = right;
   assign if_c.left  = left;
   assign if_c.right = right;

   pos_selector #(.N_POS(4), .WRAP(1'b0), .RPT_DELAY(16), .RPT_PERIOD(4)) dut_a (
      .clk(clk), .first_pos(first_pos), .bus(if_a));
   pos_selector #(.N_POS(6), .WRAP(1'b1), .RPT_DELAY(16), .RPT_PERIOD(4)) dut_b (
      .clk(clk), .first_pos(first_pos), .bus(if_b));
   pos_selector #(.N_POS(16), .WRAP(1'b0), .RPT_DELAY(16), .RPT_PERIOD(4)) dut_c (
      .clk(clk), .first_pos(first_pos), .bus(if_c));

   logic [63:0] o_pos [ND];
   logic [63:0] o_sel [ND];
   logic [2:0]  o_flg [ND];

   assign o_pos[0] = 64'(if_a.pos);
   assign o_pos[1] = 64'(if_b.pos);
   assign o_pos[2] = 64'(if_c.pos);
   assign o_sel[0] = 64'(if_a.sel);
   assign o_sel[1] = 64'(if_b.sel);
   assign o_sel[2] = 64'(if_c.sel);
   assign o_flg[0] = {if_a.at_min, if_a.at_max, if_a.moved};
   assign o_flg[1] = {if_b.at_min, if_b.at_max, if_b.moved};
   assign o_flg[2] = {if_c.at_min, if_c.at_max, if_c.moved};

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
   endtask

   // Reference model: a press is a 0->1 of the raw button seen two edges before
   // the edge that moves the cursor; hist[0] is the sample one edge ago.
   int np [ND] = '{4, 6, 16};
   bit wr [ND] = '{1'b0, 1'b1, 1'b0};
   int m_pos [ND];
   bit m_moved [ND];
   bit hl [3];
   bit hr [3];
   int run;

   task automatic model_reset();
      for (int d = 0; d < ND; d++) begin
         m_pos[d]   = 1;
         m_moved[d] = 1'b0;
      end
      for (int i = 0; i < 3; i++) begin
         hl[i] = 1'b0;
         hr[i] = 1'b0;
      end
      run = 0;
   endtask

   task automatic model_edge(input bit l, input bit r);
      bit pl;
      bit pr;
      pl = hl[1] & ~hl[2];
      pr = hr[1] & ~hr[2];
`ifdef POS_AUTOREPEAT_EN
      if (!(hl[1] ^ hr[1])) run = 0;
      else if (pl || pr) run = 1;
      else begin
         run++;
         if (run - 1 >= 16 && (run - 1 - 16) % 4 == 0) begin
            pl = hl[1];
            pr = hr[1];
         end
      end
`endif
      for (int d = 0; d < ND; d++) begin
         int nxt;
         nxt = m_pos[d];
         if (pl && !pr) nxt = (m_pos[d] > 1) ? m_pos[d] - 1 : (wr[d] ? np[d] : 1);
         if (pr && !pl) nxt = (m_pos[d] < np[d]) ? m_pos[d] + 1 : (wr[d] ? 1 : np[d]);
         m_moved[d] = (nxt != m_pos[d]);
         m_pos[d]   = nxt;
      end
      hl[2] = hl[1]; hl[1] = hl[0]; hl[0] = l;
      hr[2] = hr[1]; hr[1] = hr[0]; hr[0] = r;
   endtask

   task automatic check_all();
      for (int d = 0; d < ND; d++) begin
         check_val($sformatf("pos%0d", d), o_pos[d], 64'(m_pos[d]));
         check_val($sformatf("sel%0d", d), o_sel[d], 64'd1 << (m_pos[d] - 1));
         check_val($sformatf("flags%0d", d), 64'(o_flg[d]),
                   64'({m_pos[d] == 1, m_pos[d] == np[d], m_moved[d]}));
      end
   endtask

   task automatic run_cycle(input bit l, input bit r);
      left  = l;
      right = r;
      @(posedge clk);
      model_edge(l, r);
      @(negedge clk);
      check_all();
   endtask

   task automatic press(input bit l, input bit r);
      repeat (3) run_cycle(l, r);
      repeat (3) run_cycle(1'b0, 1'b0);
   endtask

   // Entered and left on a falling clock edge; reset lands mid-cycle.
   task automatic do_reset_async();
      #2 first_pos = 1'b1;
      #1;
      for (int d = 0; d < ND; d++) begin
         check_val($sformatf("rst_pos%0d", d), o_pos[d], 64'd1);
         check_val($sformatf("rst_sel%0d", d), o_sel[d], 64'd1);
         check_val($sformatf("rst_flags%0d", d), 64'(o_flg[d]), 64'b100);
      end
      model_reset();
      @(negedge clk);
      first_pos = 1'b0;
   endtask

   initial begin
      first_pos = 1'b1;
      left      = 1'b0;
      right     = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check_all();
      first_pos = 1'b0;

      run_cycle(1'b0, 1'b1);
      run_cycle(1'b0, 1'b1);
      check_val("lat_e1_pos", o_pos[0], 64'd1);
      run_cycle(1'b0, 1'b1);
      check_val("lat_e2_pos", o_pos[0], 64'd2);
      check_val("lat_e2_sel", o_sel[0], 64'b0010);
      check_val("lat_e2_moved", 64'(o_flg[0][0]), 64'd1);
      run_cycle(1'b0, 1'b0);
      check_val("lat_e3_moved", 64'(o_flg[0][0]), 64'd0);
      repeat (3) run_cycle(1'b0, 1'b0);

      do_reset_async();
      repeat (5) press(1'b0, 1'b1);
      check_val("sat_max", o_pos[0], 64'd4);
      repeat (4) press(1'b1, 1'b0);
      check_val("sat_min", o_pos[0], 64'd1);

      do_reset_async();
      press(1'b1, 1'b0);
      check_val("wrap_to_max", o_pos[1], 64'd6);
      check_val("sat_stay_min", o_pos[0], 64'd1);
      press(1'b0, 1'b1);
      check_val("wrap_to_min", o_pos[1], 64'd1);
      check_val("step_a", o_pos[0], 64'd2);
      press(1'b1, 1'b1);
      check_val("both_a", o_pos[0], 64'd2);
      check_val("both_b", o_pos[1], 64'd1);

      repeat (100) run_cycle(1'b0, 1'b1);
      repeat (4) run_cycle(1'b0, 1'b0);

      do_reset_async();
      press(1'b0, 1'b1);
      press(1'b0, 1'b1);
      check_val("mid_pos3", o_pos[0], 64'd3);
      do_reset_async();

      left  = 1'b0;
      right = 1'b1;
      do_reset_async();
      repeat (6) run_cycle(1'b0, 1'b1);
      repeat (3) run_cycle(1'b0, 1'b0);

`ifdef POS_AUTOREPEAT_EN
      do_reset_async();
      repeat (30) run_cycle(1'b0, 1'b1);
      repeat (4) run_cycle(1'b0, 1'b0);
      check_val("rpt_first", o_pos[2], 64'd6);
      repeat (20) run_cycle(1'b0, 1'b1);
      repeat (4) run_cycle(1'b0, 1'b0);
      check_val("rpt_restart", o_pos[2], 64'd8);
`endif

      for (int seg = 0; seg < 250; seg++) begin
         bit l;
         bit r;
         int len;
         l   = ($urandom_range(0, 2) == 0);
         r   = ($urandom_range(0, 2) == 0);
         len = $urandom_range(1, 40);
         if ($urandom_range(0, 24) == 0) begin
            left  = l;
            right = r;
            do_reset_async();
         end
         repeat (len) run_cycle(l, r);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/pos_selector.md
Name: pos_selector

Overview:
- Parametrised N-position cursor register driven by left/right push-buttons.
- Outputs the current position as one-hot select lines and as a binary index; feeds menu/slot selection logic downstream.
- Fully synchronous to clk, with input synchronisers and rising-edge detection, so raw buttons are never used as clocks.
- Supports saturating or wrap-around movement.

Parameters:
- N_POS, 4, number of positions, legal range 2..64; positions are numbered 1..N_POS.
- WRAP, 0, 0 = saturate at 1 and N_POS; 1 = wrap N_POS->1 and 1->N_POS.
- RPT_DELAY, 16, auto-repeat: hold cycles before the first repeat step (only used with POS_AUTOREPEAT_EN).
- RPT_PERIOD, 4, auto-repeat: cycles between repeat steps (only used with POS_AUTOREPEAT_EN).

Ports:
- clk  input  1  system clock, rising edge.
- first_pos  input  1  reset, asynchronous, active-high; forces position 1.
- left  input  1  raw button, decrement request, asynchronous to clk.
- right  input  1  raw button, increment request, asynchronous to clk.
- sel  output  N_POS  one-hot select; sel[k-1]=1 when position = k.
- pos  output  PW  binary position 1..N_POS, where PW = $clog2(N_POS+1).
- at_min  output  1  1 when pos == 1.
- at_max  output  1  1 when pos == N_POS.
- moved  output  1  one-cycle pulse in the cycle after pos changes.

Behaviour:
- Reset (first_pos=1, any time, including mid-operation): pos=1, sel=1 (bit 0 set), at_min=1, at_max=0, moved=0, all synchroniser/edge/repeat flops=0. Takes effect asynchronously; deassertion is sampled on clk.
- Each button passes through a 2-flop synchroniser (s1,s2) plus a delay flop (s3). A press event is s2 & ~s3.
- Latency: the button is first sampled high at edge E0; the press event is valid between E1 and E2; pos updates at E2; moved=1 for the cycle E2..E3.
- Step rules, evaluated each cycle from the press events Lp/Rp:
  - Lp & Rp: no move, moved=0.
  - Lp only: if pos>1, pos-1. If pos==1: with WRAP=1 pos=N_POS, with WRAP=0 no change and moved=0.
  - Rp only: if pos<N_POS, pos+1. If pos==N_POS: with WRAP=1 pos=1, with WRAP=0 no change and moved=0.
- Press event is rising-edge only: a held button yields exactly one step (without the optional feature).
- A button held through reset release is seen as a new press once synchronised (flops reset to 0).
- sel, at_min and at_max are registered-consistent with pos in every cycle and are never multi-hot or zero.
- pos arithmetic is PW bits wide, with no overflow: bounds are checked before the add/subtract.
- moved is asserted only when pos actually changed.

Optional Feature:
- Macro: POS_AUTOREPEAT_EN.
- Defined:
  - A per-design repeat counter runs while exactly one of s2_left/s2_right is high and the other is low.
  - After RPT_DELAY cycles of continuous hold following the initial press event, a synthetic press is generated, then another every RPT_PERIOD cycles.
  - Synthetic presses obey the same step, saturate and wrap rules.
  - Counter clears on release, on both buttons held, or on reset.
- Undefined: no repeat logic is built; a held button gives a single step.

Test Plan:
- Reset/defaults: assert first_pos mid-stream with pos=3 -> pos=1, sel=0001, at_min=1 immediately without a clock edge; moved=0.
- Step latency: N_POS=4, one right pulse of 3 cycles -> pos 1->2 exactly 2 edges after first sampling; moved is a 1-cycle pulse; sel=0010.
- Saturation: WRAP=0, 5 right presses from pos 1 -> pos=4, last press gives moved=0. Then left at pos 1 -> stays 1.
- Wrap: WRAP=1, N_POS=6, right at pos 6 -> pos=1; left at pos 1 -> pos=6; moved=1 each time.
- Simultaneous and held input: both buttons rise in the same cycle -> no change. A single button held for 100 cycles without POS_AUTOREPEAT_EN -> exactly one step.
- Auto-repeat (POS_AUTOREPEAT_EN, RPT_DELAY=16, RPT_PERIOD=4, N_POS=16): right held 30 cycles from pos 1 -> steps at press+0, +16, +20, +24, +28, ending at pos=6. Release and re-hold restarts the delay.
